seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for a 4-digit common-anode 7-segment display.
- Sits downstream of the counter stages. It accepts a 16-bit BCD value plus decimal points through a load strobe and scans one digit per prescaler period.
- New values are applied atomically at frame boundaries, so a digit never shows a mix of old and new data.

---
 rtl/seg7_scan_driver.sv | 150 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver with a shadowed, frame-aligned
// load path and optional leading-zero blanking.
module seg7_scan_driver #(
    parameter int PRESCALE = 50000,
    parameter int DIV_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        pending,
    output logic        frame_tick
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(PRESCALE - 1);
    localparam logic [DIV_W-1:0] PRESC_ONE  = DIV_W'(1);

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD nibbles render as '-'.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = 7'h3F;
        endcase
        return pat;
    endfunction

    logic [DIV_W-1:0] presc_r;
    logic [1:0]       idx_r;
    logic [15:0]      shadow_val_r;
    logic [3:0]       shadow_dp_r;
    logic [15:0]      disp_val_r;
    logic [3:0]       disp_dp_r;
    logic             pending_r;
    logic             frame_tick_r;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;

    logic             tick_s;
    logic             boundary_s;
    logic [3:0]       nib_s;
    logic [3:0]       zero_s;
    logic             lead_zero_s;
    logic             blank_s;
    logic [3:0]       an_next_s;
    logic [6:0]       seg_next_s;
    logic             dp_next_s;

    assign tick_s     = (presc_r == PRESC_LAST);
    assign boundary_s = tick_s && (idx_r == 2'd3);

    // Digit selection, leading-zero detection and next output pattern.
    always_comb begin
        nib_s     = disp_val_r[{idx_r, 2'b00} +: 4];
        zero_s[0] = (disp_val_r[3:0]   == 4'd0);
        zero_s[1] = (disp_val_r[7:4]   == 4'd0);
        zero_s[2] = (disp_val_r[11:8]  == 4'd0);
        zero_s[3] = (disp_val_r[15:12] == 4'd0);
        case (idx_r)
            2'd3:    lead_zero_s = zero_s[3];
            2'd2:    lead_zero_s = zero_s[3] & zero_s[2];
            2'd1:    lead_zero_s = zero_s[3] & zero_s[2] & zero_s[1];
            default: lead_zero_s = 1'b0;
        endcase
        blank_s   = blank_lz & lead_zero_s;
        an_next_s = ~(4'b0001 << idx_r);
        if (blank_s) begin
            seg_next_s = 7'h7F;
            dp_next_s  = 1'b1;
        end else begin
            seg_next_s = bcd_to_seg(nib_s);
            dp_next_s  = ~disp_dp_r[idx_r];
        end
    end

    // Slot prescaler and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= 2'd0;
        end else if (tick_s) begin
            presc_r <= '0;
            idx_r   <= idx_r + 2'd1;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    // Shadow capture and frame-aligned transfer into the display register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_val_r <= 16'h0000;
            shadow_dp_r  <= 4'b0000;
            disp_val_r   <= 16'h0000;
            disp_dp_r    <= 4'b0000;
            pending_r    <= 1'b0;
        end else if (load && boundary_s) begin
            shadow_val_r <= value;
            shadow_dp_r  <= dp_in;
            disp_val_r   <= value;
            disp_dp_r    <= dp_in;
            pending_r    <= 1'b0;
        end else if (load) begin
            shadow_val_r <= value;
            shadow_dp_r  <= dp_in;
            pending_r    <= 1'b1;
        end else if (boundary_s && pending_r) begin
            disp_val_r   <= shadow_val_r;
            disp_dp_r    <= shadow_dp_r;
            pending_r    <= 1'b0;
        end
    end

    // Registered display outputs and frame-start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r         <= 4'b1111;
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            frame_tick_r <= 1'b0;
        end else begin
            an_r         <= an_next_s;
            seg_r        <= seg_next_s;
            dp_r         <= dp_next_s;
            frame_tick_r <= boundary_s;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign pending    = pending_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues expected frames, a
// monitor collects each displayed frame and compares when frame_tick marks it complete.
module tb_seg7_scan_driver;

    localparam int PRESCALE = 4;
    localparam int FRAME    = 4 * PRESCALE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;
    logic        frame_tick;

    seg7_scan_driver #(.PRESCALE(PRESCALE), .DIV_W(16)) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp),
        .pending(pending), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [27:0] segs;
        logic [3:0]  dps;
        logic        pend;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    // Edges since reset release; a frame k occupies edges FRAME*k+1 .. FRAME*(k+1).
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [27:0] all4(input logic [6:0] s);
        return {s, s, s, s};
    endfunction

    task automatic push(input int tag, input logic [27:0] s, input logic [3:0] d, input logic p);
        exp_t e;
        e.tag = tag; e.segs = s; e.dps = d; e.pend = p;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        int n = 0;
        while (cyc != c && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != c) chk("wait_cyc", cyc, c);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; value = v; dp_in = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Monitor state
    int         frame_no;
    int         last_tick;
    bit         have_tick;
    bit         unstable;
    int         cnt[4];
    logic [6:0] cap_seg[4];
    logic       cap_dp[4];
    logic       cap_pend;
    int         mon_d;

    always @(negedge clk) begin
        if (rst) begin
            frame_no  = 0;
            have_tick = 1'b0;
            unstable  = 1'b0;
            cap_pend  = 1'b0;
            for (int i = 0; i < 4; i++) cnt[i] = 0;
        end else begin
            case (an)
                4'b1110: mon_d = 0;
                4'b1101: mon_d = 1;
                4'b1011: mon_d = 2;
                4'b0111: mon_d = 3;
                4'b1111: mon_d = -1;
                default: begin
                    mon_d = -1;
                    chk("an_onehot", {28'd0, an}, 32'hE);
                end
            endcase
            if (mon_d >= 0) begin
                if (cnt[mon_d] == 0) begin
                    cap_seg[mon_d] = seg;
                    cap_dp[mon_d]  = dp;
                    if (mon_d == 3) cap_pend = pending;
                end else if (seg !== cap_seg[mon_d] || dp !== cap_dp[mon_d]) begin
                    unstable = 1'b1;
                end
                cnt[mon_d]++;
            end
            if (frame_tick) begin
                if (have_tick) chk("frame_period", cyc - last_tick, FRAME);
                have_tick = 1'b1;
                last_tick = cyc;
                chk("slot_len", {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])}, 32'h04040404);
                chk("slot_stable", {31'd0, unstable}, 32'd0);
                while (q.size() > 0 && q[0].tag < frame_no) begin
                    mon_e = q.pop_front();
                    chk("frame_missed", frame_no, mon_e.tag);
                end
                if (q.size() > 0 && q[0].tag == frame_no) begin
                    mon_e = q.pop_front();
                    chk($sformatf("f%0d_seg", mon_e.tag),
                        {4'd0, cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]}, {4'd0, mon_e.segs});
                    chk($sformatf("f%0d_dp", mon_e.tag),
                        {28'd0, cap_dp[3], cap_dp[2], cap_dp[1], cap_dp[0]}, {28'd0, mon_e.dps});
                    chk($sformatf("f%0d_pending", mon_e.tag), {31'd0, cap_pend}, {31'd0, mon_e.pend});
                end
                frame_no++;
                unstable = 1'b0;
                for (int i = 0; i < 4; i++) cnt[i] = 0;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_an", {28'd0, an}, 32'hF);
        chk("rel_seg", {25'd0, seg}, 32'h7F);
        push(0, all4(7'h40), 4'b1111, 1'b0);
        push(1, all4(7'h40), 4'b1111, 1'b0);

        // Mid-frame load becomes visible in the next frame
        wait_cyc(37);
        push(2, all4(7'h40), 4'b1111, 1'b1);
        push(3, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011, 1'b0);
        do_load(16'h1234, 4'b0100);
        chk("pend_rise", {31'd0, pending}, 32'd1);

        // Leading-zero blanking, including dp suppression on blanked digits
        wait_cyc(67);
        push(4, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011, 1'b1);
        do_load(16'h0007, 4'b1110);
        wait_cyc(80);
        blank_lz = 1'b1;
        wait_cyc(83);
        push(5, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1111, 1'b1);
        push(6, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111, 1'b0);
        do_load(16'h0000, 4'b0000);
        wait_cyc(112);
        blank_lz = 1'b0;

        // Two loads in one frame: the last one wins
        wait_cyc(115);
        push(7, all4(7'h40), 4'b1111, 1'b1);
        push(8, all4(7'h24), 4'b1111, 1'b0);
        do_load(16'h1111, 4'b0000);
        wait_cyc(120);
        do_load(16'h2222, 4'b0000);

        // Load exactly on the boundary edge
        wait_cyc(159);
        push(9, all4(7'h24), 4'b1111, 1'b0);
        push(10, all4(7'h10), 4'b1111, 1'b0);
        do_load(16'h9999, 4'b0000);
        chk("pend_boundary", {31'd0, pending}, 32'd0);

        // Non-BCD nibbles render as dashes
        wait_cyc(178);
        push(11, all4(7'h10), 4'b1111, 1'b1);
        push(12, all4(7'h3F), 4'b1111, 1'b0);
        do_load(16'hABCD, 4'b0000);

        // Reset mid-frame discards the pending shadow
        wait_cyc(211);
        do_load(16'hABCD, 4'b1111);
        chk("pend_before_rst", {31'd0, pending}, 32'd1);
        wait_cyc(216);
        rst = 1'b1;
        #1;
        chk("mid_rst_an", {28'd0, an}, 32'hF);
        chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
        chk("mid_rst_dp", {31'd0, dp}, 32'd1);
        chk("mid_rst_pending", {31'd0, pending}, 32'd0);
        chk("mid_rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(0, all4(7'h40), 4'b1111, 1'b0);
        push(1, all4(7'h40), 4'b1111, 1'b0);

        for (int n = 0; n < 80 && q.size() > 0; n++) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
